// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package mips_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;
    localparam int unsigned BYTES_PER_WORD = 32'd4;
    localparam int unsigned ADDR_STEP      = 32'd4;

    function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] data);
        return csum ^ data;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream big-endian into words; o_word/o_word_valid are presented
// combinationally in the cycle the last byte of a word is strobed.
module byte_packer
    import mips_loader_pkg::*;
#(
    parameter int NB_BYTE = 8,
    parameter int NB_DATA = 32
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_valid,
    input  logic [NB_BYTE-1:0] i_byte,
    output logic [NB_DATA-1:0] o_word,
    output logic               o_word_valid
);

    localparam int NB_SHIFT = NB_DATA - NB_BYTE;
    localparam logic [1:0] CNT_LAST = 2'(BYTES_PER_WORD - 32'd1);

    logic [NB_SHIFT-1:0] shift_q, shift_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                last_s;

    assign last_s       = (cnt_q == CNT_LAST);
    assign o_word       = {shift_q, i_byte};
    assign o_word_valid = i_valid && last_s && !i_clr;

    // Shift/count next state; the register is emptied once a word completes.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (i_clr) begin
            shift_d = '0;
            cnt_d   = 2'd0;
        end else if (i_valid) begin
            cnt_d = cnt_q + 2'd1;
            if (last_s) begin
                shift_d = '0;
            end else begin
                shift_d = {shift_q[NB_SHIFT-NB_BYTE-1:0], i_byte};
            end
        end else begin
            shift_d = shift_q;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            shift_q <= '0;
            cnt_q   <= 2'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads 32-bit instructions from a UART byte stream into instruction RAM until HALT.
// Optional macro INSTR_MEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module instr_mem_loader
    import mips_loader_pkg::*;
#(
    parameter int          NB_DATA   = 32,
    parameter int          NB_ADDR   = 12,
    parameter int          NB_BYTE   = 8,
    parameter logic [31:0] HALT_WORD = mips_loader_pkg::HALT_WORD
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_we,
    output logic [NB_ADDR-1:0] o_addr,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_error,
    output logic [NB_ADDR-2:0] o_word_count
);

    localparam logic [NB_ADDR-1:0] ADDR_LAST = {{(NB_ADDR-2){1'b1}}, 2'b00};
    localparam logic [NB_ADDR-1:0] ADDR_INC  = NB_ADDR'(ADDR_STEP);
    localparam logic [NB_ADDR-2:0] CNT_ONE   = {{(NB_ADDR-2){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [NB_ADDR-2:0] count_q, count_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic               we_q, we_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               start_s;
    logic               is_halt_s;
    logic               is_last_s;
    logic               pk_valid_s;
    logic [NB_DATA-1:0] pk_word_s;
    logic               pk_word_valid_s;

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    logic [NB_BYTE-1:0] csum_q, csum_d;
`endif

    assign start_s   = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign is_halt_s = (data_q == HALT_WORD);
    assign is_last_s = (addr_q == ADDR_LAST);
    // A byte in WRITE starts the next word only when the session continues.
    assign pk_valid_s = i_rx_valid &&
                        ((state_q == ST_LOAD) ||
                         ((state_q == ST_WRITE) && !is_halt_s && !is_last_s));

    byte_packer #(
        .NB_BYTE (NB_BYTE),
        .NB_DATA (NB_DATA)
    ) u_packer (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_clr        (start_s),
        .i_valid      (pk_valid_s),
        .i_byte       (i_rx_data),
        .o_word       (pk_word_s),
        .o_word_valid (pk_word_valid_s)
    );

    // Next-state, address, count and error logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_s) begin
                    state_d = ST_LOAD;
                    addr_d  = '0;
                    count_d = '0;
                    err_d   = 1'b0;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (pk_word_valid_s) begin
                    state_d = ST_WRITE;
                    data_d  = pk_word_s;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_WRITE: begin
                if (is_halt_s) begin
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
                    // A byte arriving with the HALT write is already the checksum.
                    if (i_rx_valid) begin
                        state_d = ST_DONE;
                        err_d   = (i_rx_data != csum_q);
                    end else begin
                        state_d = ST_CHECK;
                    end
`else
                    state_d = ST_DONE;
`endif
                end else if (is_last_s) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                    addr_d  = addr_q + ADDR_INC;
                    count_d = count_q + CNT_ONE;
                end
            end
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (i_rx_valid) begin
                    state_d = ST_DONE;
                    err_d   = (i_rx_data != csum_q);
                end else begin
                    state_d = ST_CHECK;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        if (pk_valid_s) begin
            csum_d = csum_update(csum_q, i_rx_data);
        end else begin
            csum_d = csum_d;
        end
`endif

        we_d   = (state_d == ST_WRITE);
        busy_d = (state_d == ST_LOAD) || (state_d == ST_WRITE) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            data_q  <= data_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    // Running XOR of accepted bytes.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign o_we         = we_q;
    assign o_addr       = addr_q;
    assign o_data       = data_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_error      = err_q;
    assign o_word_count = count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader (NB_ADDR=4 so overflow is reachable).
module tb_instr_mem_loader;

    localparam int NB_ADDR   = 4;
    localparam int ADDR_SPAN = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [7:0]          rx_data = 8'h00;
    logic                rx_valid = 1'b0;
    logic                o_we;
    logic [NB_ADDR-1:0]  o_addr;
    logic [31:0]         o_data;
    logic                o_busy;
    logic                o_done;
    logic                o_error;
    logic [NB_ADDR-2:0]  o_word_count;

    int n_pass = 0;
    int n_total = 0;
    bit check_en = 1'b0;

    logic [31:0] ram [0:3];
    int wr_cnt = 0;

    // reference model state
    bit         m_active, m_done, m_err, m_chk, m_we, m_we_prev;
    int         m_addr, m_count;
    logic [31:0] m_data;
    logic [7:0] m_xor;
    logic [7:0] q[$];

    instr_mem_loader #(.NB_ADDR(NB_ADDR)) dut (
        .clk          (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_we         (o_we),
        .o_addr       (o_addr),
        .o_data       (o_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_word_count (o_word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: collect bytes, emit a write one cycle after every 4th.
    always @(posedge clk) begin
        m_we_prev = m_we;
        m_we = 1'b0;
        if (rst) begin
            m_active = 0; m_done = 0; m_err = 0; m_chk = 0;
            m_addr = 0; m_count = 0; m_data = 32'h0; m_xor = 8'h00; q.delete();
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_done = 0; m_err = 0; m_chk = 0;
                m_addr = 0; m_count = 0; m_xor = 8'h00; q.delete();
            end
        end else begin
            if (m_we_prev) begin
                if (m_data == 32'hFFFF_FFFF) begin
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
                    m_chk = 1;
`else
                    m_active = 0; m_done = 1;
`endif
                end else if (m_addr == ADDR_SPAN - 4) begin
                    m_active = 0; m_done = 1; m_err = 1;
                end else begin
                    m_addr += 4; m_count++;
                end
            end
            if (m_active && rx_valid) begin
                if (m_chk) begin
                    m_active = 0; m_done = 1; m_chk = 0;
                    m_err = (rx_data != m_xor);
                end else begin
                    q.push_back(rx_data);
                    m_xor = m_xor ^ rx_data;
                    if (q.size() == 4) begin
                        m_data = {q[0], q[1], q[2], q[3]};
                        q.delete();
                        m_we = 1'b1;
                    end
                end
            end
        end
    end

    // Cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("we", 32'(o_we), 32'(m_we));
            chk("addr", 32'(o_addr), 32'(m_addr));
            chk("busy", 32'(o_busy), 32'(m_active));
            chk("done", 32'(o_done), 32'(m_done));
            chk("error", 32'(o_error), 32'(m_err));
            chk("word_count", 32'(o_word_count), 32'(m_count[NB_ADDR-2:0]));
            if (m_we) chk("data", o_data, m_data);
        end
    end

    // Bench-side RAM fed by the write port.
    always @(negedge clk) begin
        if (o_we) begin
            ram[o_addr[3:2]] = o_data;
            wr_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_data = b; rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
        repeat (gap) cyc();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) send(w[i*8 +: 8], gap);
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic end_session();
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        cyc();
        send(m_xor, 0);
`endif
    endtask

    task automatic wait_done();
        int n = 0;
        while (!o_done && n < 200) begin cyc(); n++; end
        chk("done_timeout", 32'(o_done), 32'd1);
        cyc();
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 4; i++) ram[i] = 32'h0;
        wr_cnt = 0;
    endtask

    initial begin
        int w0;
        clear_ram();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        check_en = 1'b1;
        chk("rst_we", 32'(o_we), 32'd0);
        chk("rst_addr", 32'(o_addr), 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_count", 32'(o_word_count), 32'd0);

        // Normal load; a byte in IDLE is ignored.
        send(8'h77, 1);
        do_start();
        send_word(32'hA5A5_A5A5, 1);
        send_word(32'h5A5A_5A5A, 0);
        send_word(32'hF0F0_F0F0, 2);
        send_word(32'hFFFF_FFFF, 1);
        end_session();
        wait_done();
        chk("norm_ram0", ram[0], 32'hA5A5_A5A5);
        chk("norm_ram1", ram[1], 32'h5A5A_5A5A);
        chk("norm_ram2", ram[2], 32'hF0F0_F0F0);
        chk("norm_ram3", ram[3], 32'hFFFF_FFFF);
        chk("norm_count", 32'(o_word_count), 32'd3);
        chk("norm_err", 32'(o_error), 32'd0);
        chk("norm_writes", 32'(wr_cnt), 32'd4);

        // Byte order with gaps; stray start and byte while DONE are ignored.
        send(8'h99, 0);
        clear_ram();
        do_start();
        send(8'h12, 0);
        send(8'h34, 5);
        start = 1'b1; cyc(); start = 1'b0;
        send(8'h56, 3);
        send(8'h78, 0);
        chk("lat_we_hi", 32'(o_we), 32'd1);
        cyc();
        chk("lat_we_lo", 32'(o_we), 32'd0);
        send_word(32'hFFFF_FFFF, 0);
        end_session();
        wait_done();
        chk("order_ram0", ram[0], 32'h1234_5678);
        chk("order_writes", 32'(wr_cnt), 32'd2);

        // Back-to-back bytes; start and byte in the same cycle drops the byte.
        clear_ram();
        start = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w0 = (i < 12) ? (8'h10 + i) : 8'hFF;
            rx_data = 8'(w0); rx_valid = 1'b1;
            cyc();
        end
        rx_valid = 1'b0;
        end_session();
        wait_done();
        chk("b2b_ram0", ram[0], 32'h1011_1213);
        chk("b2b_ram1", ram[1], 32'h1415_1617);
        chk("b2b_ram2", ram[2], 32'h1819_1A1B);
        chk("b2b_ram3", ram[3], 32'hFFFF_FFFF);

        // Overflow: the fifth word must never be written or wrap to 0.
        clear_ram();
        do_start();
        send_word(32'h1111_1111, 0);
        send_word(32'h2222_2222, 1);
        send_word(32'h3333_3333, 0);
        send_word(32'h4444_4444, 0);
        send_word(32'h5555_5555, 0);
        wait_done();
        chk("ovf_err", 32'(o_error), 32'd1);
        chk("ovf_addr", 32'(o_addr), 32'hC);
        chk("ovf_count", 32'(o_word_count), 32'd3);
        chk("ovf_writes", 32'(wr_cnt), 32'd4);
        chk("ovf_ram0", ram[0], 32'h1111_1111);
        chk("ovf_ram3", ram[3], 32'h4444_4444);

        // Reset mid-word discards the partial word.
        clear_ram();
        do_start();
        send(8'hAA, 0);
        send(8'hBB, 0);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        do_start();
        send_word(32'hDEAD_BEEF, 0);
        send_word(32'hFFFF_FFFF, 1);
        end_session();
        wait_done();
        chk("rst_ram0", ram[0], 32'hDEAD_BEEF);
        chk("rst_ram1", ram[1], 32'hFFFF_FFFF);
        chk("rst_count2", 32'(o_word_count), 32'd1);
        chk("rst_err", 32'(o_error), 32'd0);

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        // Checksum good (XOR = 04) then bad.
        do_start();
        send_word(32'h0102_0304, 0);
        send_word(32'hFFFF_FFFF, 2);
        chk("ck_busy", 32'(o_busy), 32'd1);
        send(8'h04, 0);
        wait_done();
        chk("ck_good", 32'(o_error), 32'd0);
        do_start();
        send_word(32'h0102_0304, 0);
        send_word(32'hFFFF_FFFF, 2);
        send(8'h05, 0);
        wait_done();
        chk("ck_bad", 32'(o_error), 32'd1);
`endif

        repeat (3) cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
